ula_bist: RTL and testbench

- Synthesizable built-in self-test driver and checker for the 8-bit `ula`: the initiating end of the `ula` A/B/OP→Result interface.
- On `start`, walks all four operations and drives directed plus LFSR-generated operands.
- After a settle window, compares `ula_result` against an internal reference model and accumulates pass/fail counts.
- Sits beside `ula` in the datapath and replaces the simulation-only bench for on-chip/FPGA bring-up.

---
 rtl/ula_pkg.sv | 32 +++
 rtl/ula_bist_lfsr.sv | 18 +
 rtl/ula_bist.sv | 155 +++++++++++++++
 tb/tb_ula_bist.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ula and its built-in self-test driver.
package ula_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } ula_op_t;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } bist_state_t;

    function automatic logic [DATA_W-1:0] ula_ref(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input ula_op_t op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            default: return a | b;
        endcase
    endfunction

endpackage

// File: rtl/ula_bist_lfsr.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
module ula_bist_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst || load)
            q <= seed;
        else if (step)
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    end

endmodule

// File: rtl/ula_bist.sv
// BIST driver/checker for the 8-bit ula: walks ADD/SUB/AND/OR with directed and
// LFSR operands. Optional ULA_BIST_STOP_ON_FAIL_EN halts at the first mismatch.
module ula_bist
    import ula_pkg::*;
#(
    parameter int          N_VECTORS     = 16,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       pass_count,
    output logic [15:0]       fail_count,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic [1:0]        ula_op,
    input  logic [DATA_W-1:0] ula_result,
    output logic              err_valid,
    output logic [DATA_W-1:0] err_expected,
    output logic [DATA_W-1:0] err_obtained
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    bist_state_t       state, state_next;
    logic [1:0]        op_idx;
    logic [13:0]       vec_idx;
    logic [SW-1:0]     settle_cnt;
    logic [DATA_W-1:0] expected;
    logic [DATA_W-1:0] vec_a, vec_b;
    logic [15:0]       lfsr_q;
    logic              start_ok, lfsr_step;
    logic              last_vec, last_op, settle_end, mismatch;

    assign start_ok   = (state == IDLE || state == DONE) && start;
    assign last_vec   = vec_idx == 14'(N_VECTORS - 1);
    assign last_op    = op_idx == 2'b11;
    assign settle_end = settle_cnt == SW'(SETTLE_CYCLES - 1);
    assign mismatch   = ula_result != expected;
    assign lfsr_step  = (state == DRIVE) && (vec_idx >= 14'd2);

    ula_bist_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .seed (LFSR_SEED),
        .step (lfsr_step),
        .q    (lfsr_q)
    );

    // Two directed vectors per op, LFSR operands afterwards.
    always_comb begin
        vec_a = lfsr_q[15:8];
        vec_b = lfsr_q[7:0];
        if (vec_idx == 14'd0) begin
            vec_a = 8'd10;
            vec_b = 8'd5;
        end else if (vec_idx == 14'd1) begin
            vec_a = op_idx[1] ? 8'hCC : 8'hFF;
            vec_b = op_idx[1] ? 8'hAA : 8'h01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      state_next = SETTLE;
            SETTLE:     if (settle_end) state_next = CHECK;
            CHECK: begin
`ifdef ULA_BIST_STOP_ON_FAIL_EN
                if (mismatch || (last_op && last_vec))
                    state_next = DONE;
                else
                    state_next = DRIVE;
`else
                state_next = (last_op && last_vec) ? DONE : DRIVE;
`endif
            end
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
        done = (state == DONE);
        pass = done && (fail_count == 16'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_idx       <= '0;
            vec_idx      <= '0;
            settle_cnt   <= '0;
            expected     <= '0;
            ula_a        <= '0;
            ula_b        <= '0;
            ula_op       <= '0;
            pass_count   <= '0;
            fail_count   <= '0;
            err_valid    <= 1'b0;
            err_expected <= '0;
            err_obtained <= '0;
        end else begin
            err_valid <= 1'b0;
            case (state)
                IDLE, DONE: if (start) begin
                    op_idx       <= '0;
                    vec_idx      <= '0;
                    pass_count   <= '0;
                    fail_count   <= '0;
                    err_expected <= '0;
                    err_obtained <= '0;
                end
                DRIVE: begin
                    ula_a      <= vec_a;
                    ula_b      <= vec_b;
                    ula_op     <= op_idx;
                    expected   <= ula_ref(vec_a, vec_b, ula_op_t'(op_idx));
                    settle_cnt <= '0;
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                CHECK: begin
                    if (mismatch) begin
                        fail_count   <= fail_count + 16'd1;
                        err_valid    <= 1'b1;
                        err_expected <= expected;
                        err_obtained <= ula_result;
                    end else begin
                        pass_count <= pass_count + 16'd1;
                    end
                    if (last_vec) begin
                        vec_idx <= '0;
                        op_idx  <= op_idx + 2'd1;
                    end else begin
                        vec_idx <= vec_idx + 14'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_bist.sv
// Randomized self-checking bench for ula_bist against a cycle-indexed vector model.
module tb_ula_bist;

    localparam int N  = 16;
    localparam int S  = 1;
    localparam int P  = S + 2;
    localparam int NV = 4 * N;
    localparam int T  = NV * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass, err_valid;
    logic [15:0] pass_count, fail_count;
    logic [7:0] ula_a, ula_b, ula_result, err_expected, err_obtained;
    logic [1:0] ula_op;

    int total = 0;
    int bad = 0;
    int fmode = 0;
    int fkey = 0;

    always #5 clk = ~clk;

    ula_bist #(.N_VECTORS(N), .SETTLE_CYCLES(S), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count), .ula_a(ula_a), .ula_b(ula_b),
        .ula_op(ula_op), .ula_result(ula_result), .err_valid(err_valid),
        .err_expected(err_expected), .err_obtained(err_obtained)
    );

    function automatic int ref_f(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    // Stand-in ula: correct, ADD off by one, or key-dependent bit corruption.
    function automatic logic [7:0] env_ula(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op, input int mode, input int key);
        int r;
        r = ref_f(int'(a), int'(b), int'(op));
        if (mode == 1 && op == 2'd0) r = (r + 1) % 256;
        if (mode == 2 && (((int'(a) ^ int'(b) ^ key) & 3) == 0)) r = r ^ (1 << (key % 8));
        return 8'(r);
    endfunction

    assign ula_result = env_ula(ula_a, ula_b, ula_op, fmode, fkey);

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: full vector list for a run, built from the operand rules.
    int va[NV], vb[NV], vop[NV], vexp[NV], vobt[NV];

    task automatic build();
        logic [15:0] l;
        l = 16'hACE1;
        for (int o = 0; o < 4; o++)
            for (int v = 0; v < N; v++) begin
                int i;
                i = o * N + v;
                vop[i] = o;
                if (v == 0) begin va[i] = 10; vb[i] = 5; end
                else if (v == 1) begin
                    va[i] = (o < 2) ? 255 : 204;
                    vb[i] = (o < 2) ? 1 : 170;
                end else begin
                    va[i] = int'(l[15:8]);
                    vb[i] = int'(l[7:0]);
                    l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
                end
                vexp[i] = ref_f(va[i], vb[i], o);
                vobt[i] = int'(env_ula(8'(va[i]), 8'(vb[i]), 2'(o), fmode, fkey));
            end
    endtask

    // ms: 0 idle/reset, 1 running, 2 done; k = cycles since the start-sampling edge.
    int ms = 0;
    int k = 0;
    bit armed = 1'b0;

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            ms = 0; k = 0;
        end else if (ms != 1 && start) begin
            build(); ms = 1; k = 0;
        end else if (ms != 0) begin
            k++;
            if (ms == 1 && k == T) ms = 2;
        end
    end

    int ea = 0, eb = 0, eo = 0;

    always @(negedge clk) begin
        int c, np, nf, lee, leo, u;
        bit ev;
        if (armed) begin
            np = 0; nf = 0; lee = 0; leo = 0; ev = 1'b0;
            if (ms == 0) begin
                ea = 0; eb = 0; eo = 0;
            end else begin
                c = (k / P < NV) ? k / P : NV;
                for (int i = 0; i < c; i++)
                    if (vexp[i] == vobt[i]) np++;
                    else begin nf++; lee = vexp[i]; leo = vobt[i]; end
                ev = (k > 0) && (k % P == 0) && (k / P <= NV) && (vexp[k/P-1] != vobt[k/P-1]);
                if (k >= 1) begin
                    u = ((k - 1) / P < NV) ? (k - 1) / P : NV - 1;
                    ea = va[u]; eb = vb[u]; eo = vop[u];
                end
            end
            chk("busy", int'(busy), int'(ms == 1));
            chk("done", int'(done), int'(ms == 2));
            chk("pass", int'(pass), int'(ms == 2 && nf == 0));
            chk("pass_count", int'(pass_count), np);
            chk("fail_count", int'(fail_count), nf);
            chk("err_valid", int'(err_valid), int'(ev));
            chk("err_expected", int'(err_expected), lee);
            chk("err_obtained", int'(err_obtained), leo);
            chk("ula_a", int'(ula_a), ea);
            chk("ula_b", int'(ula_b), eb);
            chk("ula_op", int'(ula_op), eo);
        end
    end

    int first_ee = -1, first_eo = -1;
    always @(negedge clk)
        if (err_valid && first_ee < 0) begin
            first_ee = int'(err_expected);
            first_eo = int'(err_obtained);
        end

    task automatic run(input bit hold, output int cyc);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 if (!hold) start = 1'b0;
        first_ee = -1; first_eo = -1;
        cyc = 0;
        while (!done && cyc < 5 * T) begin
            @(posedge clk); #2;
            cyc++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", cyc, T);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_pass_count", int'(pass_count), 0);
        chk("rst_ula_a", int'(ula_a), 0);
        rst = 1'b0;

        // clean run
        fmode = 0;
        run(1'b0, cyc);
        chk("latency", cyc, 192);
        chk("clean_pass_count", int'(pass_count), 64);
        chk("clean_fail_count", int'(fail_count), 0);
        chk("clean_pass", int'(pass), 1);
        chk("model_add_wrap", vexp[1], 8'h00);
        chk("model_sub_wrap", vexp[N+1], 8'hFE);
        chk("model_and_dir", vexp[2*N+1], 8'h88);
        chk("model_or_dir", vexp[3*N+1], 8'hEE);
        chk("model_lfsr_a", va[2], 8'hAC);
        chk("model_lfsr_b", vb[2], 8'hE1);

        // faulty ADD
        fmode = 1;
        run(1'b0, cyc);
        chk("fault_fail_count", int'(fail_count), 16);
        chk("fault_pass_count", int'(pass_count), 48);
        chk("fault_pass", int'(pass), 0);
        chk("first_err_expected", first_ee, 15);
        chk("first_err_obtained", first_eo, 16);

        // reset in the middle of the SUB vectors
        fmode = 0;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (N * P + 4) @(posedge clk);
        #2 rst = 1'b1;
        chk("pre_rst_op_sub", int'(ula_op), 1);
        @(posedge clk); #2 rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_pass_count", int'(pass_count), 0);
        chk("abort_ula_op", int'(ula_op), 0);
        run(1'b0, cyc);
        chk("rerun_latency", cyc, T);
        chk("rerun_pass_count", int'(pass_count), 64);

        // start held through a run, then re-pulsed in DONE
        run(1'b1, cyc);
        chk("held_latency", cyc, T);
        chk("held_pass_count", int'(pass_count), 64);
        run(1'b0, cyc);
        chk("repulse_pass_count", int'(pass_count), 64);

        // randomized corruption keys and idle gaps
        for (int r = 0; r < 3; r++) begin
            fmode = 2;
            fkey = int'($urandom_range(0, 255));
            repeat ($urandom_range(0, 7)) @(posedge clk);
            run(1'b0, cyc);
            chk("rand_total", int'(pass_count) + int'(fail_count), NV);
        end

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
